// File: rtl/readout_scheduler.sv
// Per-event readout sequencer: L1 accept -> eventStart, round-robin pixel hits, quiet trailer cycle.
// Events past MAXHITS are truncated and the leftover pixel hits are drained and discarded.
module readout_scheduler #(
    parameter int NPIX    = 16,
    parameter int MAXHITS = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              l1aValid,
    input  logic [11:0]       l1aBCID,
    input  logic [7:0]        l1aL1Counter,
    output logic              l1aAck,
    input  logic [NPIX-1:0]   hitReq,
    input  logic [31*NPIX-1:0] hitData,
    output logic [NPIX-1:0]   hitGrant,
    input  logic              stall,
    output logic              eventStart,
    output logic              hit,
    output logic [7:0]        pixelID,
    output logic [28:0]       TDCData,
    output logic [1:0]        EA,
    output logic [11:0]       BCID,
    output logic [7:0]        L1Counter,
    output logic              busy,
    output logic              truncated,
    output logic [15:0]       eventCount
);
    localparam int PW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [7:0] MAXC = 8'(MAXHITS);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t        state;
    logic [PW-1:0] rrPtr;
    logic [7:0]    hitCnt;

    logic [NPIX-1:0] rot;
    logic            reqAny;
    logic [PW-1:0]   selIdx;
    logic [PW-1:0]   nextPtr;
    logic [30:0]     selData;
    logic            grantEn;

    // Rotate requests so bit 0 is rrPtr; the first set bit is the round-robin winner.
    always_comb begin
        int off;
        int s;
        off    = 0;
        s      = 0;
        reqAny = 1'b0;
        rot    = NPIX'({hitReq, hitReq} >> rrPtr);
        for (int k = 0; k < NPIX; k++) begin
            if (!reqAny && rot[k]) begin
                reqAny = 1'b1;
                off    = k;
            end
        end
        s = int'(rrPtr) + off;
        if (s >= NPIX) s = s - NPIX;
        selIdx  = PW'(s);
        nextPtr = (selIdx == PW'(NPIX - 1)) ? '0 : selIdx + 1'b1;
        selData = '0;
        for (int k = 0; k < NPIX; k++) begin
            if (PW'(k) == selIdx) selData = hitData[31*k +: 31];
        end
    end

    // Grants and acks are FIFO pops, so they must vanish during stall and reset.
    always_comb begin
        grantEn = 1'b0;
        if (reqAny && !stall && !reset) begin
            if (state == SCAN && hitCnt < MAXC) grantEn = 1'b1;
            if (state == DRAIN)                 grantEn = 1'b1;
        end
    end

    assign hitGrant = grantEn ? (NPIX'(1) << selIdx) : '0;
    assign l1aAck   = (state == IDLE) && l1aValid && !stall && !reset;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rrPtr      <= '0;
            hitCnt     <= '0;
            eventStart <= 1'b0;
            hit        <= 1'b0;
            pixelID    <= '0;
            TDCData    <= '0;
            EA         <= '0;
            BCID       <= '0;
            L1Counter  <= '0;
            truncated  <= 1'b0;
            eventCount <= '0;
        end else if (!stall) begin
            eventStart <= 1'b0;
            hit        <= 1'b0;
            truncated  <= 1'b0;
            case (state)
                IDLE: begin
                    if (l1aValid) begin
                        eventStart <= 1'b1;
                        BCID       <= l1aBCID;
                        L1Counter  <= l1aL1Counter;
                        hitCnt     <= '0;
                        rrPtr      <= '0;
                        eventCount <= eventCount + 16'd1;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (!reqAny) begin
                        state <= IDLE;
                    end else if (hitCnt < MAXC) begin
                        hit     <= 1'b1;
                        pixelID <= 8'(selIdx);
                        EA      <= selData[30:29];
                        TDCData <= selData[28:0];
                        hitCnt  <= hitCnt + 8'd1;
                        rrPtr   <= nextPtr;
                    end else begin
                        truncated <= 1'b1;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!reqAny) state <= IDLE;
                    else         rrPtr <= nextPtr;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_readout_scheduler.sv
// Directed bench for readout_scheduler with an L1/pixel buffer model and a hit scoreboard.
`timescale 1ns/1ps
module tb_readout_scheduler;
    localparam int NPIX = 16;
    localparam int MAXH = 4;

    typedef struct packed {
        logic [NPIX-1:0] mask;
        logic [11:0]     bcid;
        logic [7:0]      l1c;
    } evt_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              l1aValid = 1'b0;
    logic [11:0]       l1aBCID = '0;
    logic [7:0]        l1aL1Counter = '0;
    logic              l1aAck;
    logic [NPIX-1:0]   hitReq;
    logic [31*NPIX-1:0] hitData;
    logic [NPIX-1:0]   hitGrant;
    logic              stall = 1'b0;
    logic              eventStart, hit, busy, truncated;
    logic [7:0]        pixelID, L1Counter;
    logic [28:0]       TDCData;
    logic [1:0]        EA;
    logic [11:0]       BCID;
    logic [15:0]       eventCount;

    readout_scheduler #(.NPIX(NPIX), .MAXHITS(MAXH)) dut (
        .clk(clk), .reset(reset), .l1aValid(l1aValid), .l1aBCID(l1aBCID),
        .l1aL1Counter(l1aL1Counter), .l1aAck(l1aAck), .hitReq(hitReq), .hitData(hitData),
        .hitGrant(hitGrant), .stall(stall), .eventStart(eventStart), .hit(hit),
        .pixelID(pixelID), .TDCData(TDCData), .EA(EA), .BCID(BCID), .L1Counter(L1Counter),
        .busy(busy), .truncated(truncated), .eventCount(eventCount)
    );

    always #12 clk = ~clk;

    int nTests = 0;
    int nFails = 0;
    int nAck = 0, nGrant = 0, nHit = 0, nStart = 0, nTrunc = 0;
    int cyc = 0;

    evt_t evQ[$];
    evt_t hdrQ[$];
    int   expQ[$];
    int   startCyc[$];

    logic [NPIX-1:0] pend = '0;
    logic [NPIX-1:0] np;
    logic [NPIX-1:0] gS = '0;
    logic            aS = 1'b0;
    evt_t            mh;
    int              mp;
    logic [30:0]     md;

    function automatic logic [30:0] pixData(int i);
        return {2'(i + 1), 29'(i * 1000 + 5)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    assign hitReq = pend;
    always_comb begin
        hitData = '0;
        for (int i = 0; i < NPIX; i++) hitData[31*i +: 31] = pend[i] ? pixData(i) : 31'h0;
    end

    // L1 buffer and pixel FIFOs: pops take effect at the edge after a grant/ack is seen.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        np = pend & ~gS;
        if (!reset && aS && evQ.size() > 0) begin
            np = evQ[0].mask;
            void'(evQ.pop_front());
        end
        pend <= reset ? '0 : np;
        if (evQ.size() > 0) begin
            l1aValid     <= 1'b1;
            l1aBCID      <= evQ[0].bcid;
            l1aL1Counter <= evQ[0].l1c;
        end else begin
            l1aValid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            gS <= '0;
            aS <= 1'b0;
        end else begin
            gS <= hitGrant;
            aS <= l1aAck;
            if (hitGrant != '0) begin
                nGrant++;
                chk("grant one-hot", 64'($onehot(hitGrant)), 1);
            end
            if (l1aAck) nAck++;
            if (!stall && eventStart) begin
                nStart++;
                startCyc.push_back(cyc);
                chk("header expected", 64'(hdrQ.size() != 0), 1);
                if (hdrQ.size() != 0) begin
                    mh = hdrQ.pop_front();
                    chk("BCID", BCID, mh.bcid);
                    chk("L1Counter", L1Counter, mh.l1c);
                end
                chk("hit during eventStart", hit, 0);
            end
            if (!stall && hit) begin
                nHit++;
                chk("hit expected", 64'(expQ.size() != 0), 1);
                if (expQ.size() != 0) begin
                    mp = expQ.pop_front();
                    md = pixData(mp);
                    chk("pixelID", pixelID, mp);
                    chk("TDCData", TDCData, md[28:0]);
                    chk("EA", EA, md[30:29]);
                end
            end
            if (!stall && truncated) nTrunc++;
        end
    end

    task automatic pushEvt(input logic [NPIX-1:0] mask, input logic [11:0] bcid, input logic [7:0] l1c);
        int c = 0;
        evQ.push_back('{mask, bcid, l1c});
        hdrQ.push_back('{mask, bcid, l1c});
        for (int i = 0; i < NPIX; i++) begin
            if (mask[i] && c < MAXH) begin
                expQ.push_back(i);
                c++;
            end
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic waitAcks(input int target);
        int n = 0;
        while (nAck < target && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("l1aAck seen", 64'(nAck >= target), 1);
    endtask

    task automatic waitIdle;
        int n = 0;
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        while (busy && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("back to IDLE", busy, 0);
    endtask

    int a0, g0, h0, s0, t0, sb;

    initial begin
        // Reset state
        #30;
        chk("rst eventStart", eventStart, 0);
        chk("rst hit", hit, 0);
        chk("rst busy", busy, 0);
        chk("rst eventCount", eventCount, 0);
        chk("rst BCID", BCID, 0);
        chk("rst truncated", truncated, 0);
        chk("rst l1aAck", l1aAck, 0);
        tick;
        reset = 1'b0;

        // One event with hits on pixels 2,5,9
        a0 = nAck; g0 = nGrant; h0 = nHit; s0 = nStart;
        pushEvt(16'h0224, 12'h123, 8'h07);
        waitAcks(a0 + 1);
        waitIdle;
        chk("ev1 quiet hit", hit, 0);
        chk("ev1 hits", nHit - h0, 3);
        chk("ev1 grants", nGrant - g0, 3);
        chk("ev1 acks", nAck - a0, 1);
        chk("ev1 starts", nStart - s0, 1);
        chk("ev1 eventCount", eventCount, 1);
        chk("ev1 scoreboard empty", expQ.size(), 0);

        // Empty event: header then trailer
        tick;
        h0 = nHit; s0 = nStart;
        pushEvt(16'h0000, 12'hABC, 8'h08);
        waitAcks(nAck + 1);
        waitIdle;
        chk("empty hits", nHit - h0, 0);
        chk("empty starts", nStart - s0, 1);
        chk("empty eventCount", eventCount, 2);
        chk("empty BCID held", BCID, 12'hABC);

        // Stall for 5 cycles after the 2nd hit
        tick;
        h0 = nHit;
        pushEvt(16'h1086, 12'h456, 8'h09);
        waitAcks(nAck + 1);
        tick;
        tick;
        tick;
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("stall hit held", hit, 1);
            chk("stall pixelID held", pixelID, 2);
            chk("stall TDC held", TDCData, 29'(2 * 1000 + 5));
            chk("stall no grant", hitGrant, 0);
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
        waitIdle;
        chk("stall hits", nHit - h0, 4);
        chk("stall eventCount", eventCount, 3);

        // Truncation at MAXHITS with pixels 0..5 requesting
        tick;
        h0 = nHit; g0 = nGrant; t0 = nTrunc;
        pushEvt(16'h003F, 12'h777, 8'h0A);
        waitAcks(nAck + 1);
        waitIdle;
        chk("trunc hits", nHit - h0, 4);
        chk("trunc grants", nGrant - g0, 6);
        chk("trunc pulses", nTrunc - t0, 1);
        chk("trunc cleared", truncated, 0);
        chk("trunc pixels drained", hitReq, 0);

        // Three back-to-back events with l1aValid held high
        tick;
        sb = startCyc.size();
        h0 = nHit; a0 = nAck;
        pushEvt(16'h0011, 12'h001, 8'h10);
        pushEvt(16'h0300, 12'h002, 8'h11);
        pushEvt(16'h8001, 12'h003, 8'h12);
        waitAcks(a0 + 3);
        waitIdle;
        chk("b2b starts", startCyc.size() - sb, 3);
        chk("b2b spacing 1", startCyc[sb+1] - startCyc[sb], 4);
        chk("b2b spacing 2", startCyc[sb+2] - startCyc[sb+1], 4);
        chk("b2b hits", nHit - h0, 6);
        chk("b2b eventCount", eventCount, 7);

        // Reset in the middle of a hit stream
        tick;
        pushEvt(16'h0078, 12'h5A5, 8'h20);
        waitAcks(nAck + 1);
        tick;
        tick;
        tick;
        chk("pre-reset hit", hit, 1);
        reset = 1'b1;
        #1;
        chk("arst hit", hit, 0);
        chk("arst pixelID", pixelID, 0);
        chk("arst TDCData", TDCData, 0);
        chk("arst BCID", BCID, 0);
        chk("arst L1Counter", L1Counter, 0);
        chk("arst busy", busy, 0);
        chk("arst eventCount", eventCount, 0);
        chk("arst grant", hitGrant, 0);
        expQ.delete();
        hdrQ.delete();
        pushEvt(16'h0202, 12'h0F0, 8'h21);
        tick;
        @(negedge clk);
        #1;
        chk("rst pending valid", l1aValid, 1);
        chk("rst no ack", l1aAck, 0);
        tick;
        reset = 1'b0;
        h0 = nHit;
        waitAcks(nAck + 1);
        waitIdle;
        chk("post-rst hits", nHit - h0, 2);
        chk("post-rst eventCount", eventCount, 1);
        chk("post-rst scoreboard empty", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end
endmodule

// File: doc/readout_scheduler.md
Name: readout_scheduler

Overview:
Sequences per-event readout of the pixel hit buffers into the frame builder's hit interface. It accepts one L1-accepted event at a time and emits a one-cycle eventStart. It then streams that event's pixel hits one per cycle, using round-robin arbitration over NPIX requesters, and finally leaves one quiet cycle so the frame builder emits the trailer. It sits between the L1/pixel hit buffers and the frame builder, and freezes whenever the stream buffer is almost full.

Parameters:
NPIX, 16, number of pixel requesters; legal range 1..256.
MAXHITS, 255, maximum hits forwarded per event; legal range 1..255, bounded by the 8-bit trailer hit count.

Ports:
clk  in  1  40 MHz clock
reset  in  1  asynchronous, active-high reset
l1aValid  in  1  L1 event pending
l1aBCID  in  12  BCID of pending event
l1aL1Counter  in  8  L1 counter of pending event
l1aAck  out  1  combinational pop of the pending L1 event
hitReq  in  NPIX  pixel i holds a hit for the current event
hitData  in  31*NPIX  pixel i at [31i+30:31i] = {EA[1:0], TDC[28:0]}
hitGrant  out  NPIX  combinational one-hot pop to the selected pixel
stall  in  1  streamBufAlmostFull
eventStart  out  1  registered, to frame builder
hit  out  1  registered, to frame builder
pixelID  out  8  registered
TDCData  out  29  registered
EA  out  2  registered
BCID  out  12  registered, held for the whole event
L1Counter  out  8  registered, held for the whole event
busy  out  1  state != IDLE
truncated  out  1  registered one-cycle pulse when an event is cut at MAXHITS
eventCount  out  16  events started, wraps at 0xFFFF -> 0

Behaviour:
- Reset (async): state IDLE; all outputs and internal registers 0; rrPtr 0; hitCnt 0.
- Stall freeze: while stall=1 there is no state, pointer or output register change; l1aAck=0 and hitGrant=0. The frame builder samples only on non-stalled edges, so held outputs are read correctly on resume.
- All rules below apply only on edges where stall=0.
- Requester contract: grant/ack acts as a FIFO read enable. hitReq[i] and hitData reflect the post-pop value on the cycle after a grant.
- State IDLE:
  - Outputs hit, eventStart, truncated are 0.
  - If l1aValid: l1aAck=1 this cycle. Register eventStart<=1, BCID<=l1aBCID, L1Counter<=l1aL1Counter. Clear hitCnt and rrPtr. eventCount+1. Go to SCAN.
  - Latency: l1aValid sampled at edge t gives eventStart high during cycle t+1.
- State SCAN:
  - Select the first i with hitReq[i]=1, searching rrPtr, rrPtr+1, ..., NPIX-1, 0, ..., rrPtr-1 (modulo NPIX).
  - If a request exists and hitCnt<MAXHITS:
    - hitGrant[i]=1 this cycle.
    - Register hit<=1, pixelID<=i, {EA,TDCData}<=hitData slice i, eventStart<=0.
    - hitCnt+1; rrPtr<=(i+1) mod NPIX. Stay in SCAN.
  - If hitReq==0: register hit<=0, eventStart<=0, go to IDLE. This quiet output cycle produces the frame builder trailer.
  - Empty event: eventStart cycle is immediately followed by the quiet cycle (header then trailer).
  - If hitReq!=0 and hitCnt==MAXHITS: register hit<=0, truncated<=1 (one cycle), go to DRAIN.
- State DRAIN:
  - Outputs hit=0.
  - Grant one pending request per cycle using the same round-robin order; that data is discarded.
  - When hitReq==0, go to IDLE.
  - l1aValid is not acknowledged until IDLE.
- Back-to-back events: minimum spacing is one quiet cycle between the last hit and the next eventStart. l1aValid held high yields eventStart at most every (hits+2) cycles.
- BCID and L1Counter are stable from eventStart until the next eventStart.
- l1aValid during SCAN/DRAIN is ignored, not lost; it stays pending in the L1 buffer.
- Reset mid-event: outputs go to 0 immediately. No grant/ack is issued while reset is high; the partial event is abandoned.

Test Plan:
- One event, hitReq bits {2,5,9}, l1aBCID=0x123, l1aL1Counter=0x07:
  - eventStart for 1 cycle with BCID=0x123, L1Counter=0x07.
  - hit on 3 consecutive cycles with pixelID 2, 5, 9 and matching TDC/EA; grants one-hot on the same cycles.
  - Then one hit=0 cycle; l1aAck pulsed exactly once.
- Empty event (hitReq=0): eventStart cycle, then a quiet cycle, back to IDLE; eventCount increments by 1.
- 4 hits with stall=1 for 5 cycles after the 2nd hit:
  - Outputs hold pixel 2's values for all 5 cycles with no grants.
  - Remaining hits resume in order; total hit=1 non-stalled cycles = 4.
- MAXHITS=4, requests on pixels 0..5: hits 0, 1, 2, 3 forwarded; truncated pulses once; pixels 4 and 5 are granted during DRAIN with hit=0; then IDLE.
- l1aValid held high for 3 events of 2 hits each: the pattern eventStart, hit, hit, quiet repeats with no gaps; eventCount=3.
- Reset asserted in the middle of the SCAN hits: all outputs 0 asynchronously; after release, a new event starts cleanly with rrPtr=0.
